dual_port_ram: RTL and testbench
================================

Name: dual_port_ram

Overview:
- Synchronous true dual-port RAM: two independent read/write ports (A, B) on one clock, with registered read data.
- Used as character VRAM in the display path. Port A is the CPU-side character writer; port B is the scan-out reader.
- The instance used for VRAM is ADDR_WIDTH=11, DATA_WIDTH=56, READ_LATENCY=1.
- Each VRAM word is {fg[23:0], bg[23:0], code[7:0]}.

Parameters:
- ADDR_WIDTH, 11, address bits per port. Depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 56, word width in bits.
- READ_LATENCY, 1, cycles from a read request to valid q. Legal values are 1 or 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- address_a  input  ADDR_WIDTH  port A word address.
- wren_a  input  1  port A write enable.
- data_a  input  DATA_WIDTH  port A write data.
- rden_a  input  1  port A read enable.
- q_a  output  DATA_WIDTH  port A read data.
- address_b  input  ADDR_WIDTH  port B word address.
- wren_b  input  1  port B write enable.
- data_b  input  DATA_WIDTH  port B write data. Narrower sources are zero-extended by the instantiator.
- rden_b  input  1  port B read enable.
- q_b  output  DATA_WIDTH  port B read data.

Behaviour:
- Memory array: 2**ADDR_WIDTH x DATA_WIDTH. All words are zero at power-up/configuration. Reset does not clear the array.
- Reset:
  - While rst=1, q_a, q_b and all internal read pipeline registers are 0. This takes effect asynchronously.
  - Writes are blocked while rst=1.
  - First rising edge after rst deasserts operates normally.
  - Reset asserted mid-read discards the in-flight read; q returns 0.
- Write: on a rising edge with wren_x=1, mem[address_x] <= data_x.
- Read:
  - On a rising edge with rden_x=1, the word at address_x is captured.
  - With READ_LATENCY=1, it appears on q_x after that edge.
  - With READ_LATENCY=2, it appears one edge later through a second register. That register loads every cycle the first stage was loaded.
  - With rden_x=0, q_x holds its previous value. In the 2-stage case the pipeline holds.
- Same-port read-during-write (wren_x=rden_x=1, same edge): read-first. q_x returns the word as it was before the write.
- Cross-port read-during-write: port B reads the address port A writes on the same edge (or vice versa). The reader gets the old data; the new data is visible from the next read.
- Simultaneous writes from A and B to the same address on the same edge: port A wins; port B's write is dropped. Different addresses both commit.
- Addresses are full-width with no wrap logic. Every ADDR_WIDTH value is a valid word.
- Port A and port B are fully symmetric apart from the write-collision priority.
- No handshake or back-pressure: a new request may be issued every cycle on each port.
- Out-of-range parameter (READ_LATENCY not 1 or 2): elaboration-time error.

Test Plan:
- Reset: hold rst=1, toggle clk with rden_a=rden_b=1 -> q_a=q_b=0. Assert rst asynchronously mid-cycle after q_b=0x123 -> q_b drops to 0 without a clock edge.
- Basic write/read: A writes 0x00FF00_000000_41 to addr 0x005. Next cycle B reads addr 0x005 with rden_b=1 -> q_b=0x00FF00_00000041 one edge later. Unwritten addr 0x7FF reads 0.
- Read hold: after q_b=0x41 from addr 5, drop rden_b and change address_b to 6 -> q_b stays 0x41.
- Cross-port collision read: addr 10 holds 0xAA. Same edge: A writes 0xBB to addr 10, B reads addr 10 -> q_b=0xAA. Next B read -> 0xBB.
- Write-write collision: same edge, A writes 0x1 and B writes 0x2 to addr 20 -> a subsequent read returns 0x1. Also A writes addr 21 while B writes addr 22 in the same edge -> both commit.
- Same-port read-first and streaming: A writes 0x7 to addr 3 (holding 0x5) with rden_a=1 -> q_a=0x5. Back-to-back reads of addrs 0..3 on B -> q_b yields each word one cycle later, with no bubbles.

Source files
------------

// File: rtl/dual_port_ram.sv
// dual_port_ram: synchronous true dual-port RAM with registered read data.
// Two symmetric read/write ports share one clock. Reads are read-first,
// both same-port and cross-port. When both ports write one address on the
// same edge, port A's write is kept and port B's is dropped. The read path
// is one or two register stages deep, and rst clears it asynchronously.
// The memory array itself is never cleared by rst.
module dual_port_ram #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 56,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  rden_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  rden_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Stop elaboration if the read latency is anything other than 1 or 2.
  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("dual_port_ram: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  // The array starts out all zero at configuration time.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Gather each port's signals into arrays so both read paths can come from one loop.
  logic [ADDR_WIDTH-1:0] addr_p [2];
  logic                  rden_p [2];
  logic [DATA_WIDTH-1:0] q_p    [2];

  assign addr_p[0] = address_a;
  assign addr_p[1] = address_b;
  assign rden_p[0] = rden_a;
  assign rden_p[1] = rden_b;
  assign q_a       = q_p[0];
  assign q_b       = q_p[1];

  // Write qualifiers. rst blocks both ports. Port B is also suppressed
  // when port A writes the same address on the same edge.
  logic we_a;
  logic we_b;
  logic addr_collide;

  assign addr_collide = (address_a == address_b);
  assign we_a         = wren_a & ~rst;
  assign we_b         = wren_b & ~rst & ~(wren_a & addr_collide);

  // Commit writes to the array. The array is not reset.
  always_ff @(posedge clk) begin
    if (we_b) begin
      mem[address_b] <= data_b;
    end
    if (we_a) begin
      mem[address_a] <= data_a;
    end
  end

  // Per-port read pipeline.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_WIDTH-1:0] stage1_reg;

      // First read stage. It samples the pre-write contents, which gives
      // read-first behaviour, and holds its value while rden is low.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage1_reg <= '0;
        end else if (rden_p[gi]) begin
          stage1_reg <= mem[addr_p[gi]];
        end
      end

      if (READ_LATENCY == 2) begin : g_lat2
        logic                  loaded_reg;
        logic [DATA_WIDTH-1:0] stage2_reg;

        // Second stage. It loads on the cycle after stage 1 loaded, so the
        // whole pipeline holds while rden stays low.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            loaded_reg <= 1'b0;
            stage2_reg <= '0;
          end else begin
            loaded_reg <= rden_p[gi];
            if (loaded_reg) begin
              stage2_reg <= stage1_reg;
            end
          end
        end

        assign q_p[gi] = stage2_reg;
      end else begin : g_lat1
        assign q_p[gi] = stage1_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed self-checking bench for dual_port_ram at the
// VRAM configuration (11-bit address, 56-bit data, read latency 1).
module tb_dual_port_ram;

  localparam int AW = 11;
  localparam int DW = 56;

  logic          clk;
  logic          rst;
  logic [AW-1:0] address_a;
  logic          wren_a;
  logic [DW-1:0] data_a;
  logic          rden_a;
  logic [DW-1:0] q_a;
  logic [AW-1:0] address_b;
  logic          wren_b;
  logic [DW-1:0] data_b;
  logic          rden_b;
  logic [DW-1:0] q_b;

  int checks = 0;
  int errors = 0;

  dual_port_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address_a(address_a),
    .wren_a(wren_a),
    .data_a(data_a),
    .rden_a(rden_a),
    .q_a(q_a),
    .address_b(address_b),
    .wren_b(wren_b),
    .data_b(data_b),
    .rden_b(rden_b),
    .q_b(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge, then settle 1 time unit past it.
  // Inputs are driven and outputs are sampled at that settled point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] stream_exp [4];

  initial begin
    rst       = 1'b1;
    address_a = '0;
    wren_a    = 1'b0;
    data_a    = '0;
    rden_a    = 1'b1;
    address_b = '0;
    wren_b    = 1'b0;
    data_b    = '0;
    rden_b    = 1'b1;

    // Reset held with reads enabled. A write to addr 30 is attempted and must be blocked.
    address_a = 11'd30;
    wren_a    = 1'b1;
    data_a    = 56'hDEAD;
    tick(); tick(); tick();
    check("reset_q_a", q_a, '0);
    check("reset_q_b", q_b, '0);

    // Release reset, then write to addr 5 from port A.
    rst       = 1'b0;
    rden_a    = 1'b0;
    rden_b    = 1'b0;
    address_a = 11'h005;
    data_a    = 56'h00FF0000000041;
    wren_a    = 1'b1;
    tick();
    wren_a    = 1'b0;
    address_b = 11'h005;
    rden_b    = 1'b1;
    tick();
    check("basic_read_b", q_b, 56'h00FF0000000041);

    // With rden_b low, q_b holds even though the address changes.
    rden_b    = 1'b0;
    address_b = 11'h006;
    tick();
    check("read_hold_b", q_b, 56'h00FF0000000041);

    // Addr 0x7FF was never written, and the write to addr 30 happened during reset.
    rden_b    = 1'b1;
    address_b = 11'h7FF;
    tick();
    check("unwritten_7ff", q_b, '0);
    address_b = 11'd30;
    tick();
    check("write_blocked_in_rst", q_b, '0);

    // Cross-port read-during-write: B reads addr 10 on the same edge A writes it.
    rden_b    = 1'b0;
    address_a = 11'd10;
    data_a    = 56'hAA;
    wren_a    = 1'b1;
    tick();
    data_a    = 56'hBB;
    address_b = 11'd10;
    rden_b    = 1'b1;
    tick();
    check("cross_old_data", q_b, 56'hAA);
    wren_a    = 1'b0;
    tick();
    check("cross_new_data", q_b, 56'hBB);

    // Both ports write addr 20 on the same edge, so port A must win.
    // Then the ports write different addresses on the same edge, and both must commit.
    rden_b    = 1'b0;
    address_a = 11'd20;
    data_a    = 56'h1;
    wren_a    = 1'b1;
    address_b = 11'd20;
    data_b    = 56'h2;
    wren_b    = 1'b1;
    tick();
    address_a = 11'd21;
    data_a    = 56'h21;
    address_b = 11'd22;
    data_b    = 56'h22;
    tick();
    wren_a    = 1'b0;
    wren_b    = 1'b0;
    address_a = 11'd20;
    rden_a    = 1'b1;
    address_b = 11'd21;
    rden_b    = 1'b1;
    tick();
    check("ww_collide_a_wins", q_a, 56'h1);
    check("ww_diff_addr_21", q_b, 56'h21);
    address_b = 11'd22;
    tick();
    check("ww_diff_addr_22", q_b, 56'h22);

    // Same-port read-first: addr 3 holds 5, and A writes 7 there with rden_a set.
    rden_a    = 1'b0;
    rden_b    = 1'b0;
    address_a = 11'd3;
    data_a    = 56'h5;
    wren_a    = 1'b1;
    tick();
    data_a    = 56'h7;
    rden_a    = 1'b1;
    tick();
    check("same_port_read_first", q_a, 56'h5);
    wren_a    = 1'b0;
    tick();
    check("same_port_after_write", q_a, 56'h7);

    // Streaming: fill addrs 0..2 from port A, then read addrs 0..3 on B in back-to-back cycles.
    rden_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      address_a = AW'(i);
      data_a    = 56'h100 + DW'(i);
      wren_a    = 1'b1;
      tick();
    end
    wren_a        = 1'b0;
    stream_exp[0] = 56'h100;
    stream_exp[1] = 56'h101;
    stream_exp[2] = 56'h102;
    stream_exp[3] = 56'h7;
    rden_b        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address_b = AW'(i);
      tick();
      check($sformatf("stream_b_addr%0d", i), q_b, stream_exp[i]);
    end

    // Asynchronous reset mid-cycle: q_b must drop to 0 with no clock edge.
    rden_b    = 1'b0;
    address_a = 11'd40;
    data_a    = 56'h123;
    wren_a    = 1'b1;
    tick();
    wren_a    = 1'b0;
    address_b = 11'd40;
    rden_b    = 1'b1;
    address_a = 11'd5;
    rden_a    = 1'b1;
    tick();
    check("pre_async_q_b", q_b, 56'h123);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q_b", q_b, '0);
    check("async_rst_q_a", q_a, '0);
    #1;
    rst = 1'b0;
    // The first edge after reset operates normally, and the array kept its contents.
    tick();
    check("post_rst_read_b", q_b, 56'h123);
    check("post_rst_read_a", q_a, 56'h00FF0000000041);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always ends, even if the directed sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion of directed sequence");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
